score_keeper: RTL and testbench

- Consumes the per-frame collision/round events from the pixel generator: hit[2:0] is one bit per dragon, and round_end flags that the robot died.
- Produces the registered score, the high score and the round count for the BCD converters and the seven-segment display.
- Replaces the ad-hoc inline score logic with:
  - edge-qualified event counting, so a level held across several ticks scores once;
  - a combo multiplier;
  - saturation;
  - a game-over hold phase.

---
 rtl/score_pkg.sv | 23 ++
 rtl/score_edge_det.sv | 21 ++
 rtl/score_keeper.sv | 141 ++++++++++++++
 tb/tb_score_keeper.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the score keeper: state encodings, default widths
// and the saturating adder used for score, high score and round count.
package score_pkg;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_PAUSED = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    localparam int SCORE_W   = 14;
    localparam int MAX_SCORE = 9999;

    // Clamp a+b to max; operands are small enough that the 32-bit sum never wraps.
    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned max);
        int unsigned sum;
        sum = a + b;
        return (sum > max) ? max : sum;
    endfunction

endpackage

// File: rtl/score_edge_det.sv
// Rising-edge detector: registers the previous input value so a level held
// across several ticks produces a single-tick rise pulse.
module score_edge_det #(
    parameter int W = 4
) (
    input  logic         clk_22,
    input  logic         rst,
    input  logic [W-1:0] in,
    output logic [W-1:0] rise
);

    logic [W-1:0] in_q;

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) in_q <= '0;
        else      in_q <= in;
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/score_keeper.sv
// Score keeper: edge-qualified hit counting with saturating score, high score,
// round count and a timed game-over hold. Combo multiplier enabled by SCORE_COMBO_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_PLAY   | hits score, combo timer runs, round_end rise ends the round
// ST_PAUSED | everything frozen until pause drops
// ST_OVER   | finished score on display, hold counts down (frozen by pause)
module score_keeper #(
    parameter int SCORE_W   = score_pkg::SCORE_W,
    parameter int MAX_SCORE = score_pkg::MAX_SCORE,
    parameter int COMBO_WIN = 8,
    parameter int COMBO_MAX = 3,
    parameter int OVER_HOLD = 24
) (
    input  logic               clk_22,
    input  logic               rst,
    input  logic               pause,
    input  logic [2:0]         hit,
    input  logic               round_end,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] h_score,
    output logic [SCORE_W-1:0] rounds,
    output logic [1:0]         combo,
    output logic               new_high,
    output logic [1:0]         state
);
    import score_pkg::*;

`ifdef SCORE_COMBO_EN
    localparam bit COMBO_EN = 1'b1;
`else
    localparam bit COMBO_EN = 1'b0;
`endif

    localparam int TMR_W  = $clog2(COMBO_WIN + 1);
    localparam int HOLD_W = $clog2(OVER_HOLD + 1);

    state_t             st;
    logic [TMR_W-1:0]   timer;
    logic [HOLD_W-1:0]  hold;
    logic [3:0]         rise;
    logic [2:0]         hit_rise;
    logic               end_rise;
    logic [1:0]         n;
    logic [1:0]         combo_nx, combo_play;
    logic [TMR_W-1:0]   timer_play;
    int unsigned        add;
    logic [SCORE_W-1:0] s_post, rounds_inc;

    score_edge_det #(.W(4)) u_edge (
        .clk_22 (clk_22),
        .rst    (rst),
        .in     ({hit, round_end}),
        .rise   (rise)
    );

    assign hit_rise = rise[3:1];
    assign end_rise = rise[0];
    assign n        = 2'(hit_rise[0]) + 2'(hit_rise[1]) + 2'(hit_rise[2]);
    assign state    = st;

    // Next combo/timer/score as seen from PLAY; with the combo feature off the
    // timer is held at zero and folds away.
    always_comb begin
        combo_nx   = '0;
        combo_play = combo;
        timer_play = timer;
        add        = 32'(n);
        if (COMBO_EN) begin
            if (timer != '0)
                combo_nx = (32'(combo) >= COMBO_MAX) ? 2'(COMBO_MAX) : combo + 2'd1;
            add = 32'(n) * (32'(combo_nx) + 32'd1);
            if (n != 2'd0) begin
                combo_play = combo_nx;
                timer_play = TMR_W'(COMBO_WIN);
            end else if (timer != '0) begin
                timer_play = timer - TMR_W'(1);
                if (timer == TMR_W'(1)) combo_play = '0;
            end
        end else begin
            combo_play = '0;
            timer_play = '0;
        end
        s_post     = SCORE_W'(sat_add(32'(score), add, MAX_SCORE));
        rounds_inc = SCORE_W'(sat_add(32'(rounds), 32'd1, MAX_SCORE));
    end

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            st       <= ST_PLAY;
            score    <= '0;
            h_score  <= '0;
            rounds   <= '0;
            combo    <= '0;
            new_high <= 1'b0;
            timer    <= '0;
            hold     <= '0;
        end else begin
            case (st)
                ST_PLAY: begin
                    if (end_rise) begin
                        score    <= s_post;
                        combo    <= combo_play;
                        timer    <= timer_play;
                        h_score  <= (s_post > h_score) ? s_post : h_score;
                        new_high <= (s_post > h_score);
                        rounds   <= rounds_inc;
                        hold     <= HOLD_W'(OVER_HOLD);
                        st       <= ST_OVER;
                    end else if (pause) begin
                        st <= ST_PAUSED;
                    end else begin
                        score <= s_post;
                        combo <= combo_play;
                        timer <= timer_play;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) st <= ST_PLAY;
                end
                ST_OVER: begin
                    if (!pause) begin
                        if (hold <= HOLD_W'(1)) begin
                            hold     <= '0;
                            score    <= '0;
                            combo    <= '0;
                            timer    <= '0;
                            new_high <= 1'b0;
                            st       <= ST_PLAY;
                        end else begin
                            hold <= hold - HOLD_W'(1);
                        end
                    end
                end
                default: st <= ST_PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed steps push hand-computed expectations,
// negedge monitors pop and compare. A second instance with a 1-tick hold covers round saturation.
module tb_score_keeper;

`ifdef SCORE_COMBO_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic        clk_22 = 1'b0;
    logic        rst = 1'b0, pause = 1'b0, round_end = 1'b0;
    logic [2:0]  hit = 3'b000;
    logic [13:0] score, h_score, rounds;
    logic [1:0]  combo, state;
    logic        new_high;

    logic        rst_f = 1'b0, pause_f = 1'b0, round_end_f = 1'b0;
    logic [2:0]  hit_f = 3'b000;
    logic [13:0] score_f, h_score_f, rounds_f;
    logic [1:0]  combo_f, state_f;
    logic        new_high_f;

    score_keeper u_dut (
        .clk_22(clk_22), .rst(rst), .pause(pause), .hit(hit), .round_end(round_end),
        .score(score), .h_score(h_score), .rounds(rounds), .combo(combo),
        .new_high(new_high), .state(state)
    );

    score_keeper #(.OVER_HOLD(1)) u_fast (
        .clk_22(clk_22), .rst(rst_f), .pause(pause_f), .hit(hit_f), .round_end(round_end_f),
        .score(score_f), .h_score(h_score_f), .rounds(rounds_f), .combo(combo_f),
        .new_high(new_high_f), .state(state_f)
    );

    always #5 clk_22 = ~clk_22;

    typedef struct {
        int    cyc;
        int    sc, hs, rd, cb, nh, st;
        string name;
    } exp_t;

    exp_t q_main[$];
    exp_t q_fast[$];
    int   cyc = 0;
    int   n_checks = 0, n_fail = 0;
    int   tag_m = 0, tag_f = 0;
    bit   done_f = 1'b0;

    always @(posedge clk_22) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, want %0d (cycle %0d)", nm, fld, act, req, cyc);
        end
    endtask

    task automatic check(input exp_t e, input int sc, input int hs, input int rd,
                         input int cb, input int nh, input int st);
        cmp(e.name, "score",    sc, e.sc);
        cmp(e.name, "h_score",  hs, e.hs);
        cmp(e.name, "rounds",   rd, e.rd);
        cmp(e.name, "combo",    cb, e.cb);
        cmp(e.name, "new_high", nh, e.nh);
        cmp(e.name, "state",    st, e.st);
    endtask

    always @(negedge clk_22) begin
        exp_t e;
        while (q_main.size() > 0 && q_main[0].cyc == cyc) begin
            e = q_main.pop_front();
            check(e, int'(score), int'(h_score), int'(rounds), int'(combo),
                  int'(new_high), int'(state));
        end
    end

    always @(negedge clk_22) begin
        exp_t e;
        while (q_fast.size() > 0 && q_fast[0].cyc == cyc) begin
            e = q_fast.pop_front();
            check(e, int'(score_f), int'(h_score_f), int'(rounds_f), int'(combo_f),
                  int'(new_high_f), int'(state_f));
        end
    end

    task automatic step(input bit p, input logic [2:0] h, input bit r);
        @(negedge clk_22);
        pause = p; hit = h; round_end = r;
        tag_m = cyc + 1;
    endtask

    task automatic exp_m(input string nm, input int sc, input int hs, input int rd,
                         input int cb, input int nh, input int st);
        exp_t e;
        e.cyc = tag_m; e.name = nm;
        e.sc = sc; e.hs = hs; e.rd = rd; e.cb = cb; e.nh = nh; e.st = st;
        q_main.push_back(e);
    endtask

    task automatic step_f(input bit r);
        @(negedge clk_22);
        round_end_f = r;
        tag_f = cyc + 1;
    endtask

    task automatic exp_f(input string nm, input int rd, input int st);
        exp_t e;
        e.cyc = tag_f; e.name = nm;
        e.sc = 0; e.hs = 0; e.rd = rd; e.cb = 0; e.nh = 0; e.st = st;
        q_fast.push_back(e);
    endtask

    // Round-count saturation: 2 ticks per round with a 1-tick hold.
    initial begin
        step_f(1'b0);
        step_f(1'b0);
        rst_f = 1'b1;
        for (int i = 0; i < 9999; i++) begin
            step_f(1'b1);
            if (i == 0) exp_f("fast_first", 1, 2);
            step_f(1'b0);
        end
        exp_f("fast_9999", 9999, 0);
        step_f(1'b1);
        exp_f("fast_sat", 9999, 2);
        step_f(1'b0);
        done_f = 1'b1;
    end

    initial begin
        int s0, s1, se;
        s0 = CE ? 17 : 8;
        s1 = s0 + 2;
        se = s1 + 1;

        // reset holds everything at zero even with inputs active
        step(1'b0, 3'b111, 1'b1); exp_m("in_reset", 0, 0, 0, 0, 0, 0);
        step(1'b0, 3'b000, 1'b0); rst = 1'b1; exp_m("released", 0, 0, 0, 0, 0, 0);

        // held level scores once
        step(1'b0, 3'b001, 1'b0); exp_m("hold_first", 1, 0, 0, 0, 0, 0);
        repeat (4) begin step(1'b0, 3'b001, 1'b0); exp_m("hold_level", 1, 0, 0, 0, 0, 0); end
        step(1'b0, 3'b000, 1'b0); exp_m("hold_fall", 1, 0, 0, 0, 0, 0);
        repeat (8) step(1'b0, 3'b000, 1'b0);

        // combo build-up and cap
        step(1'b0, 3'b111, 1'b0); exp_m("combo_l0", 4, 0, 0, 0, 0, 0);
        repeat (2) step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b010, 1'b0); exp_m("combo_l1", CE ? 6 : 5, 0, 0, CE ? 1 : 0, 0, 0);
        repeat (3) step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b100, 1'b0); exp_m("combo_l2", CE ? 9 : 6, 0, 0, CE ? 2 : 0, 0, 0);
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b001, 1'b0); exp_m("combo_l3", CE ? 13 : 7, 0, 0, CE ? 3 : 0, 0, 0);
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b010, 1'b0); exp_m("combo_cap", s0, 0, 0, CE ? 3 : 0, 0, 0);
        repeat (7) step(1'b0, 3'b000, 1'b0);
        exp_m("combo_keep", s0, 0, 0, CE ? 3 : 0, 0, 0);
        step(1'b0, 3'b000, 1'b0); exp_m("combo_expire", s0, 0, 0, 0, 0, 0);

        // hits 9 ticks apart never combo
        step(1'b0, 3'b001, 1'b0); exp_m("spaced_a", s0 + 1, 0, 0, 0, 0, 0);
        repeat (8) step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b001, 1'b0); exp_m("spaced_b", s1, 0, 0, 0, 0, 0);
        repeat (9) step(1'b0, 3'b000, 1'b0);

        // pause: entry-tick hit and paused hits are lost
        step(1'b1, 3'b010, 1'b0); exp_m("pause_in", s1, 0, 0, 0, 0, 1);
        step(1'b1, 3'b010, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b100, 1'b0); exp_m("pause_hit", s1, 0, 0, 0, 0, 1);
        step(1'b0, 3'b100, 1'b0); exp_m("resume", s1, 0, 0, 0, 0, 0);
        step(1'b0, 3'b100, 1'b0); exp_m("resume_held", s1, 0, 0, 0, 0, 0);
        step(1'b0, 3'b000, 1'b0);

        // round end with same-tick hit, new high, 24 unpaused hold ticks
        step(1'b0, 3'b100, 1'b1); exp_m("end_new", se, se, 1, 0, 1, 2);
        repeat (10) step(1'b0, 3'b011, 1'b0);
        exp_m("over_hits", se, se, 1, 0, 1, 2);
        repeat (3) step(1'b1, 3'b011, 1'b0);
        exp_m("over_paused", se, se, 1, 0, 1, 2);
        repeat (13) step(1'b0, 3'b000, 1'b0);
        exp_m("over_last", se, se, 1, 0, 1, 2);
        step(1'b0, 3'b000, 1'b0); exp_m("over_done", 0, se, 1, 0, 0, 0);

        // pause and end_rise together: round ends, no new high
        step(1'b0, 3'b001, 1'b0); exp_m("post_over", 1, se, 1, 0, 0, 0);
        step(1'b1, 3'b000, 1'b1); exp_m("pause_end", 1, se, 2, 0, 0, 2);
        repeat (23) step(1'b0, 3'b000, 1'b0);
        exp_m("over2_last", 1, se, 2, 0, 0, 2);
        step(1'b0, 3'b000, 1'b0); exp_m("over2_done", 0, se, 2, 0, 0, 0);

        // ramp to the ceiling
        for (int i = 0; i < 3332; i++) begin
            step(1'b0, 3'b111, 1'b0);
            repeat (8) step(1'b0, 3'b000, 1'b0);
        end
        exp_m("ramp", 9996, se, 2, 0, 0, 0);
        step(1'b0, 3'b011, 1'b0); exp_m("ramp_9998", 9998, se, 2, 0, 0, 0);
        repeat (8) step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b111, 1'b0); exp_m("sat_9999", 9999, se, 2, 0, 0, 0);
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b100, 1'b0); exp_m("sat_hold", 9999, se, 2, CE ? 1 : 0, 0, 0);

        // reset during OVER
        step(1'b0, 3'b000, 1'b1); exp_m("end_max", 9999, 9999, 3, CE ? 1 : 0, 1, 2);
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        #2 rst = 1'b0;
        exp_m("rst_over", 0, 0, 0, 0, 0, 0);
        step(1'b0, 3'b000, 1'b0); rst = 1'b1; exp_m("rst_rel", 0, 0, 0, 0, 0, 0);
        step(1'b0, 3'b000, 1'b0);

        while (!done_f) @(negedge clk_22);
        repeat (2) @(negedge clk_22);
        cmp("drain", "main_left", q_main.size(), 0);
        cmp("drain", "fast_left", q_fast.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
